// File: rtl/fpu_pkg.sv
// Shared op encodings, latency classes and sequencer states for the FPU execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  // Arithmetic ops with dedicated latency classes
  localparam logic [4:0] OP_FADD     = 5'b01010;
  localparam logic [4:0] OP_FSUB     = 5'b01011;
  localparam logic [4:0] OP_FMUL     = 5'b01100;
  localparam logic [4:0] OP_FDIV     = 5'b01101;

  // Single-cycle ops: moves, sign-inject, convert, min/max, class, compare
  localparam logic [4:0] OP_FMV_W_X  = 5'b10000;
  localparam logic [4:0] OP_FSGNJ    = 5'b10001;
  localparam logic [4:0] OP_FSGNJN   = 5'b10010;
  localparam logic [4:0] OP_FSGNJX   = 5'b10011;
  localparam logic [4:0] OP_FCVT_S_W = 5'b10100;
  localparam logic [4:0] OP_FCVT_S_WU= 5'b10101;
  localparam logic [4:0] OP_FCVT_W_S = 5'b10110;
  localparam logic [4:0] OP_FCVT_WU_S= 5'b10111;
  localparam logic [4:0] OP_FCLASS   = 5'b11000;
  localparam logic [4:0] OP_FMIN     = 5'b11001;
  localparam logic [4:0] OP_FMAX     = 5'b11010;
  localparam logic [4:0] OP_FLE      = 5'b11011;
  localparam logic [4:0] OP_FLT      = 5'b11100;
  localparam logic [4:0] OP_FEQ      = 5'b11101;

  // Fused multiply-add family
  localparam logic [4:0] OP_FMADD0   = 5'b11110;
  localparam logic [4:0] OP_FMADD1   = 5'b11111;

  typedef enum logic [2:0] {CLS_ADD, CLS_MUL, CLS_DIV, CLS_FMA, CLS_MISC} fpu_class_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_state_e;

endpackage

// File: rtl/fpu_exec_seq_if.sv
// Issue/writeback bundle of the FPU execute sequencer, including the result-mux tap.
// Latency: n/a (wires only).
// Backpressure: valid_i/ready_o on issue, wb_valid_o/wb_ready_i on writeback.
// Ports: master = issue stage + datapath + writeback side, slave = the sequencer.
interface fpu_exec_seq_if;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_sel_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic [4:0]  op_sel_q_o;
  logic [31:0] result_fpu_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_to_int_o;
  logic        wb_illegal_o;
  logic        busy_o;

  modport master (
    output valid_i, op_sel_i, rd_i, flush_i, result_fpu_i, wb_ready_i,
    input  ready_o, op_sel_q_o, wb_valid_o, wb_data_o, wb_rd_o,
           wb_to_int_o, wb_illegal_o, busy_o
  );

  modport slave (
    input  valid_i, op_sel_i, rd_i, flush_i, result_fpu_i, wb_ready_i,
    output ready_o, op_sel_q_o, wb_valid_o, wb_data_o, wb_rd_o,
           wb_to_int_o, wb_illegal_o, busy_o
  );
endinterface

// File: rtl/fpu_op_decode.sv
// Decodes op_sel into its latency class, cycle count, integer-destination and illegal flags.
// Latency: combinational.
// Backpressure: none.
// Ports: i_op_sel in; o_lat, o_to_int, o_illegal out.
module fpu_op_decode
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_W    = 5,
  parameter int unsigned ADD_LAT  = 3,
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned FMA_LAT  = 7,
  parameter int unsigned MISC_LAT = 1
) (
  input  logic [4:0]       i_op_sel,
  output logic [LAT_W-1:0] o_lat,
  output logic             o_to_int,
  output logic             o_illegal
);

  fpu_class_e w_cls;

  always_comb begin
    w_cls     = CLS_MISC;
    o_to_int  = 1'b0;
    o_illegal = 1'b0;
    case (i_op_sel)
      OP_FADD, OP_FSUB:       w_cls = CLS_ADD;
      OP_FMUL:                w_cls = CLS_MUL;
      OP_FDIV:                w_cls = CLS_DIV;
      OP_FMADD0, OP_FMADD1:   w_cls = CLS_FMA;
      OP_FCVT_W_S, OP_FCVT_WU_S, OP_FCLASS,
      OP_FLE, OP_FLT, OP_FEQ: o_to_int = 1'b1;
      OP_FMV_W_X, OP_FSGNJ, OP_FSGNJN, OP_FSGNJX,
      OP_FCVT_S_W, OP_FCVT_S_WU, OP_FMIN, OP_FMAX: ;
      // Undefined encodings run through the single-cycle path and are flagged
      default:                o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_lat = LAT_W'(MISC_LAT);
    case (w_cls)
      CLS_ADD: o_lat = LAT_W'(ADD_LAT);
      CLS_MUL: o_lat = LAT_W'(MUL_LAT);
      CLS_DIV: o_lat = LAT_W'(DIV_LAT);
      CLS_FMA: o_lat = LAT_W'(FMA_LAT);
      default: o_lat = LAT_W'(MISC_LAT);
    endcase
  end

endmodule

// File: rtl/fpu_exec_seq.sv
// Sequences one FP op at a time: registers op_sel, counts its class latency, captures the mux result.
// Latency: wb_valid_o rises LAT cycles after the accept edge (LAT per op class, 1..2^LAT_W-1).
// Backpressure: ready_o low while busy; result held in DONE until wb_ready_i; flush_i drops everything.
// Ports: clk_i, rst_ni (async active-low), bus (fpu_exec_seq_if.slave).
module fpu_exec_seq
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_W    = 5,
  parameter int unsigned ADD_LAT  = 3,
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned FMA_LAT  = 7,
  parameter int unsigned MISC_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fpu_exec_seq_if.slave bus
);

  localparam int unsigned LAT_MAX = (1 << LAT_W) - 1;

  if (ADD_LAT < 1 || ADD_LAT > LAT_MAX || MUL_LAT < 1 || MUL_LAT > LAT_MAX ||
      DIV_LAT < 1 || DIV_LAT > LAT_MAX || FMA_LAT < 1 || FMA_LAT > LAT_MAX ||
      MISC_LAT < 1 || MISC_LAT > LAT_MAX) begin : g_lat_range_err
    $error("fpu_exec_seq: every latency must lie in 1..2^LAT_W-1");
  end

  seq_state_e       r_state, w_state_nxt;
  logic [LAT_W-1:0] r_cnt;
  logic [4:0]       r_op_sel, r_rd, r_wb_rd;
  logic             r_to_int, r_illegal, r_wb_to_int, r_wb_illegal;
  logic [31:0]      r_wb_data;

  logic [LAT_W-1:0] w_lat;
  logic             w_to_int, w_illegal, w_ready, w_accept, w_cnt_zero;

  fpu_op_decode #(
    .LAT_W(LAT_W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT), .FMA_LAT(FMA_LAT), .MISC_LAT(MISC_LAT)
  ) u_dec (
    .i_op_sel (bus.op_sel_i),
    .o_lat    (w_lat),
    .o_to_int (w_to_int),
    .o_illegal(w_illegal)
  );

  // Accepting in DONE alongside the writeback handshake gives bubble-free issue;
  // flush masks ready so a killed cycle can never admit a new op.
  assign w_ready    = !bus.flush_i && (r_state == IDLE || (r_state == DONE && bus.wb_ready_i));
  assign w_accept   = bus.valid_i && w_ready;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = BUSY;
        BUSY:    if (w_cnt_zero) w_state_nxt = DONE;
        DONE:    if (bus.wb_ready_i) w_state_nxt = w_accept ? BUSY : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt        <= '0;
      r_op_sel     <= '0;
      r_rd         <= '0;
      r_to_int     <= 1'b0;
      r_illegal    <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rd      <= '0;
      r_wb_to_int  <= 1'b0;
      r_wb_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op_sel  <= bus.op_sel_i;
      r_rd      <= bus.rd_i;
      r_cnt     <= w_lat - LAT_W'(1);
      r_to_int  <= w_to_int;
      r_illegal <= w_illegal;
    end else if (bus.flush_i) begin
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      if (w_cnt_zero) begin
        // Sample the mux on the last counted edge; op_sel_q has been steering it all along
        r_wb_data    <= bus.result_fpu_i;
        r_wb_rd      <= r_rd;
        r_wb_to_int  <= r_to_int;
        r_wb_illegal <= r_illegal;
      end else begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
    end
  end

  assign bus.ready_o      = w_ready;
  assign bus.op_sel_q_o   = r_op_sel;
  assign bus.wb_valid_o   = (r_state == DONE);
  assign bus.wb_data_o    = r_wb_data;
  assign bus.wb_rd_o      = r_wb_rd;
  assign bus.wb_to_int_o  = r_wb_to_int;
  assign bus.wb_illegal_o = r_wb_illegal;
  assign bus.busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_exec_seq.sv
// Directed bench for fpu_exec_seq: latency per class, back-to-back issue, writeback stall,
// flush, illegal op and asynchronous reset, all against hand-computed expectations.
module tb_fpu_exec_seq;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk_i = ~clk_i;

  fpu_exec_seq_if bus ();

  fpu_exec_seq u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer an op while the sequencer is ready and take the accept edge; valid_i stays high.
  task automatic issue(input string tag, input logic [4:0] op, input logic [4:0] rd,
                       input logic [31:0] res);
    bus.valid_i      = 1'b1;
    bus.op_sel_i     = op;
    bus.rd_i         = rd;
    bus.result_fpu_i = res;
    #1;
    check_eq({tag, " ready at offer"}, 32'(bus.ready_o), 32'd1);
    step();
  endtask

  // Count edges from the accept edge until wb_valid_o, and cycles with ready_o low.
  task automatic wait_wb(input string tag, input int exp_lat);
    int n  = 0;
    int lo = 0;
    #1;
    while (!bus.wb_valid_o && n < 40) begin
      if (!bus.ready_o) lo++;
      step();
      #1;
      n++;
    end
    check_eq({tag, " latency"}, 32'(n), 32'(exp_lat));
    check_eq({tag, " ready low cycles"}, 32'(lo), 32'(exp_lat));
  endtask

  // Number of cycles over a window in which wb_valid_o was seen high.
  task automatic count_wb(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.wb_valid_o) seen++;
      step();
    end
    check_eq({tag, " stray wb_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_ni           = 1'b0;
    bus.valid_i      = 1'b0;
    bus.op_sel_i     = '0;
    bus.rd_i         = '0;
    bus.flush_i      = 1'b0;
    bus.result_fpu_i = '0;
    bus.wb_ready_i   = 1'b1;

    // Reset state
    #12;
    check_eq("rst wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check_eq("rst busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst op_sel_q", 32'(bus.op_sel_q_o), 32'd0);
    check_eq("rst wb_data", bus.wb_data_o, 32'd0);
    step();
    rst_ni = 1'b1;
    #1;
    check_eq("post-rst ready", 32'(bus.ready_o), 32'd1);

    // fadd, 3 cycles
    issue("fadd", 5'b01010, 5'd3, 32'h4040_0000);
    bus.valid_i = 1'b0;
    check_eq("fadd op_sel_q", 32'(bus.op_sel_q_o), 32'h0A);
    wait_wb("fadd", 3);
    check_eq("fadd data", bus.wb_data_o, 32'h4040_0000);
    check_eq("fadd rd", 32'(bus.wb_rd_o), 32'd3);
    check_eq("fadd to_int", 32'(bus.wb_to_int_o), 32'd0);
    check_eq("fadd illegal", 32'(bus.wb_illegal_o), 32'd0);
    step();
    check_eq("fadd idle wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check_eq("fadd idle busy", 32'(bus.busy_o), 32'd0);

    // fdiv, 16 cycles, with a second op offered throughout BUSY
    issue("fdiv", 5'b01101, 5'd7, 32'h3f00_0000);
    bus.op_sel_i = 5'b01010;
    bus.rd_i     = 5'd9;
    wait_wb("fdiv", 16);
    check_eq("fdiv op_sel_q held", 32'(bus.op_sel_q_o), 32'h0D);
    check_eq("fdiv data", bus.wb_data_o, 32'h3f00_0000);
    check_eq("fdiv rd", 32'(bus.wb_rd_o), 32'd7);
    bus.result_fpu_i = 32'h4000_0000;
    #1;
    check_eq("done+wb_ready ready", 32'(bus.ready_o), 32'd1);
    step();
    bus.valid_i = 1'b0;
    check_eq("b2b fadd op_sel_q", 32'(bus.op_sel_q_o), 32'h0A);
    wait_wb("fadd2", 3);
    check_eq("fadd2 data", bus.wb_data_o, 32'h4000_0000);
    check_eq("fadd2 rd", 32'(bus.wb_rd_o), 32'd9);
    step();

    // feq then fsgnj back-to-back
    issue("feq", 5'b11101, 5'd5, 32'h0000_0001);
    bus.op_sel_i = 5'b10001;
    bus.rd_i     = 5'd6;
    wait_wb("feq", 1);
    check_eq("feq data", bus.wb_data_o, 32'h0000_0001);
    check_eq("feq rd", 32'(bus.wb_rd_o), 32'd5);
    check_eq("feq to_int", 32'(bus.wb_to_int_o), 32'd1);
    bus.result_fpu_i = 32'hbf80_0000;
    step();
    bus.valid_i = 1'b0;
    wait_wb("fsgnj", 1);
    check_eq("fsgnj data", bus.wb_data_o, 32'hbf80_0000);
    check_eq("fsgnj rd", 32'(bus.wb_rd_o), 32'd6);
    check_eq("fsgnj to_int", 32'(bus.wb_to_int_o), 32'd0);
    step();

    // fmul with writeback stalled for 5 cycles
    bus.wb_ready_i = 1'b0;
    issue("fmul", 5'b01100, 5'd12, 32'h4120_0000);
    bus.valid_i = 1'b0;
    wait_wb("fmul", 4);
    bus.result_fpu_i = 32'hdead_beef;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("fmul hold valid", 32'(bus.wb_valid_o), 32'd1);
      check_eq("fmul hold data", bus.wb_data_o, 32'h4120_0000);
      check_eq("fmul hold rd", 32'(bus.wb_rd_o), 32'd12);
    end
    bus.wb_ready_i = 1'b1;
    step();
    check_eq("fmul after hs wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check_eq("fmul after hs busy", 32'(bus.busy_o), 32'd0);

    // fmadd flushed on cycle 4
    issue("fmadd", 5'b11110, 5'd1, 32'h1234_5678);
    bus.valid_i = 1'b0;
    step();
    step();
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    #1;
    check_eq("flush busy", 32'(bus.busy_o), 32'd0);
    check_eq("flush ready", 32'(bus.ready_o), 32'd1);
    count_wb("fmadd flushed", 10);

    // flush together with a DONE handshake and a new offer
    issue("fsgnj2", 5'b10001, 5'd2, 32'h0000_0055);
    bus.valid_i = 1'b0;
    wait_wb("fsgnj2", 1);
    bus.valid_i    = 1'b1;
    bus.op_sel_i   = 5'b01010;
    bus.rd_i       = 5'd8;
    bus.flush_i    = 1'b1;
    bus.wb_ready_i = 1'b1;
    #1;
    check_eq("flush masks ready", 32'(bus.ready_o), 32'd0);
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    check_eq("flush+hs wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check_eq("flush+hs busy", 32'(bus.busy_o), 32'd0);
    check_eq("flush+hs ready", 32'(bus.ready_o), 32'd1);
    count_wb("flush+hs", 6);

    // Illegal encoding
    issue("ill", 5'b00011, 5'd4, 32'h0000_0000);
    bus.valid_i = 1'b0;
    wait_wb("ill", 1);
    check_eq("ill flag", 32'(bus.wb_illegal_o), 32'd1);
    check_eq("ill data", bus.wb_data_o, 32'd0);
    check_eq("ill rd", 32'(bus.wb_rd_o), 32'd4);
    check_eq("ill to_int", 32'(bus.wb_to_int_o), 32'd0);
    step();

    // Reset pulsed in the middle of an fdiv
    issue("fdiv2", 5'b01101, 5'd11, 32'h0000_007f);
    bus.valid_i = 1'b0;
    repeat (5) step();
    check_eq("fdiv2 busy", 32'(bus.busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("async rst busy", 32'(bus.busy_o), 32'd0);
    check_eq("async rst op_sel_q", 32'(bus.op_sel_q_o), 32'd0);
    check_eq("async rst wb_rd", 32'(bus.wb_rd_o), 32'd0);
    check_eq("async rst illegal", 32'(bus.wb_illegal_o), 32'd0);
    check_eq("async rst wb_valid", 32'(bus.wb_valid_o), 32'd0);
    step();
    rst_ni = 1'b1;
    #1;
    check_eq("re-rst ready", 32'(bus.ready_o), 32'd1);
    count_wb("post-rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
